// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_ADDR   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   localparam logic [4:0] ALUOp_ADD  = 5'h01;
   localparam logic [4:0] ALUOp_SUBU = 5'h02;
   localparam logic [4:0] ALUOp_SLT  = 5'h03;
   localparam logic [4:0] ALUOp_OR   = 5'h04;
   localparam logic [4:0] ALUOp_SLL  = 5'h05;
   localparam logic [4:0] ALUOp_ADDI = 5'h06;
   localparam logic [4:0] ALUOp_BEQ  = 5'h07;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       mdr_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       target_write;
      logic [4:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       trap;
   } ctl_t;

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - opcode/funct to ALUOp decoder used in the execute state
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [4:0] alu_op,
   output logic       exec_legal
);

   always_comb begin
      alu_op     = ALUOp_ADD;
      exec_legal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            exec_legal = 1'b1;
            case (funct)
               FN_ADD:  alu_op = ALUOp_ADD;
               FN_SUBU: alu_op = ALUOp_SUBU;
               FN_SLT:  alu_op = ALUOp_SLT;
               FN_OR:   alu_op = ALUOp_OR;
               FN_SLL:  alu_op = ALUOp_SLL;
               default: exec_legal = 1'b0;
            endcase
         end
         OP_ADDI: begin
            exec_legal = 1'b1;
            alu_op     = ALUOp_ADDI;
         end
         OP_BEQ: begin
            exec_legal = 1'b1;
            alu_op     = ALUOp_BEQ;
         end
         default: exec_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with memory wait timeout
// Optional retire counter output enabled by MC_CTRL_RETIRE_CNT_EN.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_src,
   output logic       target_write,
   output logic [4:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       trap
`ifdef MC_CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] retire_cnt
`endif
);

   localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

   state_e        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          stall;
   logic [4:0]    exec_alu_op;
   logic          exec_legal;
   ctl_t          ctl;

   mc_alu_dec u_alu_dec (
      .opcode     (opcode),
      .funct      (funct),
      .alu_op     (exec_alu_op),
      .exec_legal (exec_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      stall   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
            else           stall   = 1'b1;
         end
         S_DECODE: begin
            if (opcode == OP_J)        state_d = S_FETCH;
            else if (is_mem_op(opcode)) state_d = S_ADDR;
            else if (exec_legal)        state_d = S_EXEC;
            else                        state_d = S_TRAP;
         end
         S_EXEC:  state_d = (opcode == OP_BEQ) ? S_FETCH : S_WB;
         S_ADDR:  state_d = S_MEM;
         S_MEM: begin
            if (mem_ready) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
            else           stall   = 1'b1;
         end
         S_WB:    state_d = S_FETCH;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      // Ready on the last allowed cycle completes normally; only a further miss traps.
      if (stall) begin
         if ((WAIT_LIMIT != 0) && (wait_q == WAIT_LAST)) state_d = S_TRAP;
         else                                            wait_d  = wait_q + 1'b1;
      end
   end

   always_comb begin
      ctl = '0;
      case (state_q)
         S_FETCH: begin
            ctl.mem_req   = 1'b1;
            ctl.alu_src_b = 2'd1;
            ctl.alu_op    = ALUOp_ADD;
            ctl.ir_write  = mem_ready;
            ctl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctl.alu_src_b    = 2'd3;
            ctl.alu_op       = ALUOp_ADD;
            ctl.target_write = 1'b1;
            if (opcode == OP_J) begin
               ctl.pc_write = 1'b1;
               ctl.pc_src   = 2'd2;
            end
         end
         S_EXEC: begin
            ctl.alu_op    = exec_alu_op;
            ctl.alu_src_a = 2'd1;
            if (opcode == OP_RTYPE) begin
               if (funct == FN_SLL) ctl.alu_src_a = 2'd2;
            end else if (opcode == OP_ADDI) begin
               ctl.alu_src_b = 2'd2;
            end else if (opcode == OP_BEQ) begin
               ctl.pc_write_cond = 1'b1;
               ctl.pc_src        = 2'd1;
            end
         end
         S_ADDR: begin
            ctl.alu_src_a = 2'd1;
            ctl.alu_src_b = 2'd2;
            ctl.alu_op    = ALUOp_ADD;
         end
         S_MEM: begin
            ctl.mem_req   = 1'b1;
            ctl.i_or_d    = 1'b1;
            ctl.mem_we    = (opcode == OP_SW);
            ctl.mdr_write = mem_ready && (opcode == OP_LW);
         end
         S_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = (opcode == OP_RTYPE);
            ctl.mem_to_reg = (opcode == OP_LW);
         end
         S_TRAP:  ctl.trap = 1'b1;
         default: ctl = '0;
      endcase
      // Gate combinationally so nothing, especially mem_we, escapes while reset is held.
      if (!rst_n) ctl = '0;
   end

   assign mem_req       = ctl.mem_req;
   assign mem_we        = ctl.mem_we;
   assign i_or_d        = ctl.i_or_d;
   assign ir_write      = ctl.ir_write;
   assign mdr_write     = ctl.mdr_write;
   assign pc_write      = ctl.pc_write;
   assign pc_write_cond = ctl.pc_write_cond;
   assign pc_src        = ctl.pc_src;
   assign target_write  = ctl.target_write;
   assign alu_op        = ctl.alu_op;
   assign alu_src_a     = ctl.alu_src_a;
   assign alu_src_b     = ctl.alu_src_b;
   assign reg_write     = ctl.reg_write;
   assign reg_dst       = ctl.reg_dst;
   assign mem_to_reg    = ctl.mem_to_reg;
   assign trap          = ctl.trap;

`ifdef MC_CTRL_RETIRE_CNT_EN
   logic [31:0] retire_q, retire_d;
   logic        retire_evt;

   always_comb begin
      retire_evt = 1'b0;
      case (state_q)
         S_DECODE: retire_evt = (opcode == OP_J);
         S_EXEC:   retire_evt = (opcode == OP_BEQ);
         S_MEM:    retire_evt = mem_ready && (opcode == OP_SW);
         S_WB:     retire_evt = 1'b1;
         default:  retire_evt = 1'b0;
      endcase
      retire_d = retire_evt ? retire_q + 32'd1 : retire_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retire_q <= '0;
      else        retire_q <= retire_d;
   end

   assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against an instruction-level model
module tb_mc_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       mdr_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       target_write;
      logic [4:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       trap;
   } exp_t;

   localparam logic [4:0] A_ADD = 5'h01, A_SUBU = 5'h02, A_SLT = 5'h03, A_OR = 5'h04;
   localparam logic [4:0] A_SLL = 5'h05, A_ADDI = 5'h06, A_BEQ = 5'h07;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write, pc_write_cond;
   logic [1:0] pc_src, alu_src_a, alu_src_b;
   logic       target_write, reg_write, reg_dst, mem_to_reg, trap;
   logic [4:0] alu_op;
   logic [31:0] retire_cnt_obs;
   exp_t       obs;
   int         errors = 0;
   int         checks = 0;
   int         retired = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.WAIT_LIMIT(15)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .pc_src(pc_src), .target_write(target_write),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap)
`ifdef MC_CTRL_RETIRE_CNT_EN
      , .retire_cnt(retire_cnt_obs)
`endif
   );

`ifndef MC_CTRL_RETIRE_CNT_EN
   assign retire_cnt_obs = '0;
`endif

   assign obs = {mem_req, mem_we, i_or_d, ir_write, mdr_write, pc_write, pc_write_cond,
                 pc_src, target_write, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
                 mem_to_reg, trap};

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // One clock: drive mem_ready, compare outputs mid-cycle, advance to 2ns past the next edge.
   task automatic cyc(input string tag, input exp_t e, input logic rdy);
      mem_ready = rdy;
      #2;
      chk(tag, 32'(obs), 32'(e));
      @(posedge clk);
      #2;
   endtask

   task automatic chk_retire(input string tag);
`ifdef MC_CTRL_RETIRE_CNT_EN
      chk(tag, retire_cnt_obs, 32'(retired));
`endif
   endtask

   function automatic logic [4:0] rtype_op(input logic [5:0] fn);
      case (fn)
         6'h20:   return A_ADD;
         6'h23:   return A_SUBU;
         6'h2A:   return A_SLT;
         6'h25:   return A_OR;
         default: return A_SLL;
      endcase
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("reset_outputs", 32'(obs), 32'h0);
      retired = 0;
      chk_retire("reset_retire");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic fetch(input int fw);
      exp_t e;
      for (int k = 0; k <= fw; k++) begin
         e = '0;
         e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_op = A_ADD;
         e.ir_write = (k == fw); e.pc_write = (k == fw);
         cyc("fetch", e, k == fw);
      end
   endtask

   task automatic decode(input logic [5:0] op);
      exp_t e;
      e = '0;
      e.alu_src_b = 2'd3; e.alu_op = A_ADD; e.target_write = 1'b1;
      if (op == 6'h02) begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
      cyc("decode", e, 1'($urandom));
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input logic z);
      exp_t e;
      opcode = op; funct = fn; zero = z;
      fetch(fw);
      decode(op);
      if (op == 6'h02) begin
         retired++;
      end else if (op == 6'h23 || op == 6'h2B) begin
         e = '0; e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.alu_op = A_ADD;
         cyc("addr", e, 1'($urandom));
         for (int k = 0; k <= mw; k++) begin
            e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1;
            e.mem_we = (op == 6'h2B);
            e.mdr_write = (op == 6'h23) && (k == mw);
            cyc("mem", e, k == mw);
         end
         if (op == 6'h23) begin
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            cyc("wb_lw", e, 1'($urandom));
         end
         retired++;
      end else begin
         e = '0; e.alu_src_a = 2'd1;
         if (op == 6'h00) begin
            e.alu_op = rtype_op(fn);
            if (fn == 6'h00) e.alu_src_a = 2'd2;
         end else if (op == 6'h08) begin
            e.alu_src_b = 2'd2; e.alu_op = A_ADDI;
         end else begin
            e.alu_op = A_BEQ; e.pc_write_cond = 1'b1; e.pc_src = 2'd1;
         end
         cyc("exec", e, 1'($urandom));
         if (op != 6'h04) begin
            e = '0; e.reg_write = 1'b1; e.reg_dst = (op == 6'h00);
            cyc("wb", e, 1'($urandom));
         end
         retired++;
      end
      chk_retire("retire_count");
   endtask

   task automatic expect_trap(input int n);
      exp_t e;
      e = '0; e.trap = 1'b1;
      for (int k = 0; k < n; k++) cyc("trap_hold", e, 1'($urandom));
   endtask

   initial begin
      logic [5:0] ops [10];
      logic [5:0] fns [5];
      exp_t e;
      ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h04, 6'h23, 6'h2B, 6'h02};
      fns = '{6'h20, 6'h23, 6'h2A, 6'h25, 6'h00};
      opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
      do_reset();

      run_instr(6'h00, 6'h20, 0, 0, 1'b0);
      run_instr(6'h00, 6'h00, 0, 0, 1'b0);
      run_instr(6'h04, 6'h11, 0, 0, 1'b1);
      run_instr(6'h04, 6'h11, 0, 0, 1'b0);
      run_instr(6'h23, 6'h3F, 0, 3, 1'b0);
      run_instr(6'h2B, 6'h00, 2, 1, 1'b0);
      run_instr(6'h08, 6'h20, 1, 0, 1'b0);
      run_instr(6'h02, 6'h00, 0, 0, 1'b0);
      run_instr(6'h08, 6'h00, 14, 0, 1'b0);
      run_instr(6'h23, 6'h00, 0, 14, 1'b0);
      run_instr(6'h2B, 6'h00, 0, 14, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [5:0] op, fn;
         op = ops[$urandom_range(9)];
         fn = (op == 6'h00) ? fns[$urandom_range(4)] : 6'($urandom);
         run_instr(op, fn, $urandom_range(3), $urandom_range(3), 1'($urandom));
      end

      opcode = 6'h00; funct = 6'h20;
      for (int k = 0; k < 15; k++) begin
         e = '0; e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_op = A_ADD;
         cyc("fetch_timeout", e, 1'b0);
      end
      expect_trap(4);
      do_reset();
      run_instr(6'h00, 6'h25, 0, 0, 1'b0);

      opcode = 6'h2B; funct = 6'h00;
      fetch(0);
      decode(6'h2B);
      e = '0; e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.alu_op = A_ADD;
      cyc("addr", e, 1'b0);
      e = '0; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = 1'b1;
      cyc("mem_pending", e, 1'b0);
      do_reset();
      run_instr(6'h00, 6'h23, 0, 0, 1'b0);
      do_reset();

      run_instr(6'h00, 6'h20, 0, 0, 1'b0);
      run_instr(6'h00, 6'h20, 1, 0, 1'b0);
      run_instr(6'h00, 6'h20, 0, 0, 1'b0);
      opcode = 6'h3F; funct = 6'h20;
      fetch(0);
      decode(6'h3F);
      expect_trap(3);
      chk_retire("retire_after_trap");
      do_reset();

      opcode = 6'h00; funct = 6'h21;
      fetch(0);
      decode(6'h00);
      expect_trap(2);
      do_reset();
      run_instr(6'h00, 6'h2A, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control FSM that produces the 5-bit ALUOp consumed by the 32-bit ALU, plus datapath mux selects and write enables.
- Consumes the ALU Zero flag (ALU result bit 0) for branch resolution.
- Sequences fetch, decode, execute, memory and writeback over a ready-based memory handshake.
- Sits between the instruction register and the datapath, alongside the ALU.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles waiting on mem_ready before trapping. A value of 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid with mem_req.
- i_or_d  out  1  address select: 0 = PC, 1 = ALU out.
- ir_write  out  1  load IR.
- mdr_write  out  1  load the memory data register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by zero.
- pc_src  out  2  PC source: 0 = ALU result, 1 = branch target register, 2 = jump address.
- target_write  out  1  load the branch target register.
- alu_op  out  5  ALUOp code to the ALU.
- alu_src_a  out  2  A operand: 0 = PC, 1 = rs, 2 = zero-extended shamt.
- alu_src_b  out  2  B operand: 0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data: 0 = ALU out, 1 = MDR.
- trap  out  1  sticky illegal-instruction or timeout flag.

Behaviour:
- Reset:
  - rst_n low sets the state to S_FETCH, clears the wait counter and trap, and forces every output to 0 while low.
  - Reset mid-operation abandons any pending memory request immediately. No write strobe is issued after rst_n falls.
- Outputs are Moore-style decodes of the current state plus opcode/funct. State advances on the rising edge of clk.
- Supported instructions:
  - R-type (opcode 0x00) with funct add 0x20, subu 0x23, slt 0x2A, or 0x25, sll 0x00.
  - addi 0x08, beq 0x04, lw 0x23, sw 0x2B, j 0x02.
- S_FETCH:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - While mem_ready=0, stay and increment the wait counter.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to S_DECODE.
- S_DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD, target_write=1.
  - j: pc_write=1, pc_src=2, then go to S_FETCH.
  - lw or sw: go to S_ADDR.
  - R-type with a supported funct, addi, beq: go to S_EXEC.
  - Anything else: go to S_TRAP.
- S_EXEC, R-type:
  - alu_src_b=0.
  - alu_src_a=2 for sll (the ALU shifts B by A[4:0]), otherwise alu_src_a=1.
  - alu_op = ADD / SUBU / SLT / OR / SLL according to funct.
  - Go to S_WB.
- S_EXEC, addi: alu_src_a=1, alu_src_b=2, alu_op=ADDI, then go to S_WB.
- S_EXEC, beq:
  - alu_src_a=1, alu_src_b=0, alu_op=BEQ, pc_write_cond=1, pc_src=1.
  - The ALU returns 1 on equal, so zero=1 means taken.
  - Go to S_FETCH.
- S_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD, then go to S_MEM.
- S_MEM:
  - Outputs: mem_req=1, i_or_d=1, mem_we=1 for sw only. Hold while mem_ready=0.
  - On mem_ready, lw: mdr_write=1, then go to S_WB.
  - On mem_ready, sw: go to S_FETCH.
- S_WB: reg_write=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - addi: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Go to S_FETCH.
- S_TRAP: every output 0 except trap=1. Exit only by reset.
- Wait counter:
  - Counts consecutive mem_ready=0 cycles in S_FETCH or S_MEM. Clears on mem_ready=1 or on any state change.
  - If WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT with mem_ready still 0, go to S_TRAP.
  - mem_ready=1 in the same cycle as the limit wins: the request completes and no trap occurs.
- Cycle counts with zero-wait memory:
  - R-type/addi: 4.
  - beq: 3.
  - j: 2.
  - lw: 5.
  - sw: 4.
- mem_req is held high and stable until mem_ready is sampled high. mem_ready outside S_FETCH/S_MEM is ignored.

Optional Feature:
- Macro MC_CTRL_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt[31:0], reset to 0.
  - Increments by 1 on each instruction completion: the S_WB exit, beq in S_EXEC, sw completing in S_MEM, and j in S_DECODE.
  - Wraps 0xFFFFFFFF → 0. Does not count in S_TRAP.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared constants stay in ctrl_encode_def.v:
  - ALUOp codes (ALUOp_ADD, ALUOp_ADDI, ALUOp_SUBU, ALUOp_SLT, ALUOp_OR, ALUOp_SLL, ALUOp_BEQ).
  - New opcode/funct defines.
  - New state encodings, S_FETCH..S_TRAP, 3 bits.
- One natural sub-module, mc_alu_dec: a combinational opcode/funct → alu_op decoder, reused by S_EXEC.

Test Plan:
- add with rs=3, rt=4, zero-wait memory → alu_op ADD in S_EXEC with alu_src_a=1, alu_src_b=0; reg_write=1, reg_dst=1 in cycle 4; back in S_FETCH at cycle 5.
- sll with funct 0x00 → alu_src_a=2, alu_op=SLL.
- beq with zero=1 → pc_write_cond=1, pc_src=1 in cycle 3.
- beq with zero=0 → same strobes, PC unchanged externally.
- lw with mem_ready delayed 3 cycles in S_MEM → mem_req held 4 cycles, mdr_write pulses once, then S_WB with mem_to_reg=1.
- mem_ready stuck at 0 with WAIT_LIMIT=15 → trap=1 after 15 fetch cycles and stays set. rst_n pulse → trap=0, mem_req=1 after release.
- opcode 0x3F → S_TRAP after S_DECODE. With MC_CTRL_RETIRE_CNT_EN, 3 prior add instructions leave retire_cnt=3, unchanged after the trap.
